// File: rtl/disp_pkg.sv
// Shared constants, derived widths and FSM state type for the stereo disparity block.
package disp_pkg;

    localparam int COLS   = 79;
    localparam int ROWS   = 16;
    localparam int DMAX   = 31;

    localparam int PIX_W  = 3;
    localparam int PROF_W = 7;
    localparam int SAD_W  = 14;
    localparam int DISP_W = 5;
    localparam int ADDR_W = 11;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SEARCH,
        FINISH
    } state_t;

endpackage

// File: rtl/column_profile.sv
// Column-sum profile of one camera buffer: accumulates pixels per column,
// with a combinational read port used by the disparity search.
module column_profile
    import disp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [COL_W-1:0]  col,
    input  logic [PIX_W-1:0]  pixel,
    input  logic [COL_W-1:0]  sel,
    output logic [PROF_W-1:0] prof
);

    logic [PROF_W-1:0] sums [COLS];

    // Clear on reset or new request, otherwise add the qualified pixel to its column
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < COLS; i++) begin
                sums[i] <= '0;
            end
        end else if (valid) begin
            sums[col] <= sums[col] + PROF_W'(pixel);
        end
    end

    assign prof = sums[sel];

endmodule

// File: rtl/stereo_disparity_calc.sv
// Reads both calc RAMs into column profiles, then searches disparities
// 0..DMAX by SAD over columns DMAX..COLS-1 and reports the best one.
module stereo_disparity_calc
    import disp_pkg::*;
#(
    parameter int COLS   = disp_pkg::COLS,
    parameter int ROWS   = disp_pkg::ROWS,
    parameter int DMAX   = disp_pkg::DMAX,
    parameter int ADDR_W = disp_pkg::ADDR_W
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic [2:0]        q_left,
    input  logic [2:0]        q_right,
    output logic              busy,
    output logic              done,
    output logic [4:0]        disparity,
    output logic [13:0]       min_sad
);

    state_t state, state_nxt;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_d;
    logic              issue;
    logic              valid_d;
    logic              clear;

    logic [COL_W-1:0]  c;
    logic [DISP_W-1:0] d;
    logic [COL_W-1:0]  rcol;
    logic [SAD_W-1:0]  sad_acc;
    logic [SAD_W-1:0]  sad_sum;
    logic [SAD_W-1:0]  best_sad;
    logic [DISP_W-1:0] best_d;
    logic [PROF_W-1:0] pl;
    logic [PROF_W-1:0] pr;
    logic              last_c;
    logic              last_d;
    logic              better;

    function automatic logic [PROF_W-1:0] abs_diff(input logic [PROF_W-1:0] a,
                                                   input logic [PROF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign clear   = (state == IDLE) && start;
    assign rcol    = c - {{(COL_W-DISP_W){1'b0}}, d};
    assign sad_sum = sad_acc + SAD_W'(abs_diff(pl, pr));
    assign last_c  = (c == COL_W'(COLS - 1));
    assign last_d  = (d == DISP_W'(DMAX));
    assign better  = (sad_sum < best_sad);

    column_profile u_left (
        .clk   (sysclk),
        .reset (reset),
        .clear (clear),
        .valid (valid_d),
        .col   (col_d),
        .pixel (q_left),
        .sel   (c),
        .prof  (pl)
    );

    column_profile u_right (
        .clk   (sysclk),
        .reset (reset),
        .clear (clear),
        .valid (valid_d),
        .col   (col_d),
        .pixel (q_right),
        .sel   (rcol),
        .prof  (pr)
    );

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; ACCUM ends on the drain cycle after the last address
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (!issue) state_nxt = SEARCH;
            SEARCH:  if (last_c && last_d) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == ACCUM) || (state == SEARCH);
        done = (state == FINISH);
    end

    // Address generation, SAD accumulation, best tracking and result registers
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rdaddr    <= '0;
            row       <= '0;
            col       <= '0;
            col_d     <= '0;
            issue     <= 1'b0;
            valid_d   <= 1'b0;
            c         <= COL_W'(DMAX);
            d         <= '0;
            sad_acc   <= '0;
            best_sad  <= '0;
            best_d    <= '0;
            disparity <= '0;
            min_sad   <= '0;
        end else begin
            valid_d <= issue;
            col_d   <= col;
            case (state)
                IDLE: begin
                    if (start) begin
                        rdaddr <= '0;
                        row    <= '0;
                        col    <= '0;
                        issue  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (issue) begin
                        if (col == COL_W'(COLS - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if ((col == COL_W'(COLS - 1)) && (row == ROW_W'(ROWS - 1))) begin
                            issue  <= 1'b0;
                            rdaddr <= '0;
                        end else begin
                            rdaddr <= rdaddr + 1'b1;
                        end
                    end else begin
                        c        <= COL_W'(DMAX);
                        d        <= '0;
                        sad_acc  <= '0;
                        best_sad <= '1;
                        best_d   <= '0;
                    end
                end
                SEARCH: begin
                    if (last_c) begin
                        sad_acc <= '0;
                        c       <= COL_W'(DMAX);
                        d       <= d + 1'b1;
                        if (better) begin
                            best_sad <= sad_sum;
                            best_d   <= d;
                        end
                        if (last_d) begin
                            disparity <= better ? d : best_d;
                            min_sad   <= better ? sad_sum : best_sad;
                        end
                    end else begin
                        sad_acc <= sad_sum;
                        c       <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
